alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 144 ++++++++++++++
 tb/tb_alu_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Shared ALU parameters, plus a round-robin front end that lets two requesters
// take turns on one shared combinational ALU.
package alu_params_pkg;
  parameter int DATA_BUS_WIDTH  = 16;
  parameter int ALU_OP_NUM_BITS = 2;
  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_SUB = 2'b01;
endpackage

module alu_arbiter #(
  parameter int DATA_BUS_WIDTH  = alu_params_pkg::DATA_BUS_WIDTH,
  parameter int ALU_OP_NUM_BITS = alu_params_pkg::ALU_OP_NUM_BITS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req0,
  input  logic                       req1,
  input  logic [ALU_OP_NUM_BITS-1:0] op0,
  input  logic [ALU_OP_NUM_BITS-1:0] op1,
  input  logic [DATA_BUS_WIDTH-1:0]  a0,
  input  logic [DATA_BUS_WIDTH-1:0]  b0,
  input  logic [DATA_BUS_WIDTH-1:0]  a1,
  input  logic [DATA_BUS_WIDTH-1:0]  b1,
  output logic                       done0,
  output logic                       done1,
  output logic [DATA_BUS_WIDTH-1:0]  result,
  output logic                       z,
  output logic                       busy,
  output logic [DATA_BUS_WIDTH-1:0]  alu_a,
  output logic [DATA_BUS_WIDTH-1:0]  alu_b,
  output logic [ALU_OP_NUM_BITS-1:0] alu_op,
  input  logic [DATA_BUS_WIDTH-1:0]  alu_result,
  input  logic                       alu_z
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t                     state_r;
  state_t                     next_state_s;
  logic                       grant_valid_s;
  logic                       grant_idx_s;
  logic                       grant_idx_r;
  logic                       ptr_r;
  logic [ALU_OP_NUM_BITS-1:0] op_r;
  logic [DATA_BUS_WIDTH-1:0]  a_r;
  logic [DATA_BUS_WIDTH-1:0]  b_r;
  logic [DATA_BUS_WIDTH-1:0]  result_r;
  logic                       z_r;
  logic                       done0_r;
  logic                       done1_r;
  logic                       busy_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and grant selection; ptr_r only breaks ties when both ask.
  always_comb begin
    next_state_s  = state_r;
    grant_valid_s = 1'b0;
    grant_idx_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req0 && req1) begin
          grant_valid_s = 1'b1;
          grant_idx_s   = ptr_r;
        end else if (req0) begin
          grant_valid_s = 1'b1;
          grant_idx_s   = 1'b0;
        end else if (req1) begin
          grant_valid_s = 1'b1;
          grant_idx_s   = 1'b1;
        end else begin
          grant_valid_s = 1'b0;
          grant_idx_s   = 1'b0;
        end
        if (grant_valid_s) begin
          next_state_s = ST_EXEC;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_EXEC: next_state_s = ST_DONE;
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Latch the winner's request at the grant edge so later input changes cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r       <= 1'b0;
      grant_idx_r <= 1'b0;
      op_r        <= {ALU_OP_NUM_BITS{1'b0}};
      a_r         <= {DATA_BUS_WIDTH{1'b0}};
      b_r         <= {DATA_BUS_WIDTH{1'b0}};
    end else if (grant_valid_s) begin
      ptr_r       <= ~grant_idx_s;
      grant_idx_r <= grant_idx_s;
      op_r        <= grant_idx_s ? op1 : op0;
      a_r         <= grant_idx_s ? a1 : a0;
      b_r         <= grant_idx_s ? b1 : b0;
    end
  end

  // Capture the ALU outcome leaving EXEC; done pulses cover exactly the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r <= {DATA_BUS_WIDTH{1'b0}};
      z_r      <= 1'b0;
      done0_r  <= 1'b0;
      done1_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      if (state_r == ST_EXEC) begin
        result_r <= alu_result;
        z_r      <= alu_z;
      end
      done0_r <= (state_r == ST_EXEC) && !grant_idx_r;
      done1_r <= (state_r == ST_EXEC) && grant_idx_r;
      busy_r  <= (next_state_s != ST_IDLE);
    end
  end

  assign alu_a  = (state_r == ST_EXEC) ? a_r  : {DATA_BUS_WIDTH{1'b0}};
  assign alu_b  = (state_r == ST_EXEC) ? b_r  : {DATA_BUS_WIDTH{1'b0}};
  assign alu_op = (state_r == ST_EXEC) ? op_r : {ALU_OP_NUM_BITS{1'b0}};

  assign result = result_r;
  assign z      = z_r;
  assign done0  = done0_r;
  assign done1  = done1_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic, checked against
// a schedule-based reference model of grants, latency and results.
module tb_alu_arbiter;
  import alu_params_pkg::*;

  localparam int W  = DATA_BUS_WIDTH;
  localparam int OW = ALU_OP_NUM_BITS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1;
  logic [OW-1:0] op0, op1;
  logic [W-1:0]  a0, b0, a1, b1;
  logic          done0, done1, z, busy;
  logic [W-1:0]  result, alu_a, alu_b, alu_result;
  logic [OW-1:0] alu_op;
  logic          alu_z;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .done0(done0), .done1(done1), .result(result), .z(z), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_z(alu_z)
  );

  function automatic logic [W-1:0] ref_alu(input logic [OW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      ALU_OP_ADD: return a + b;
      ALU_OP_SUB: return a - b;
      default:    return {W{1'b0}};
    endcase
  endfunction

  // Stand-in for the shared combinational ALU.
  always_comb begin
    alu_result = ref_alu(alu_op, alu_a, alu_b);
    alu_z      = (alu_result == {W{1'b0}});
  end

  int n_checks = 0;
  int n_errors = 0;
  int edge_n = 0;
  int grant_edge = -10;
  int free_at = 0;
  int cnt_d0 = 0;
  int cnt_d1 = 0;
  int order_q[$];
  logic          ptr = 1'b0;
  logic          gidx = 1'b0;
  logic [W-1:0]  pa = '0, pb = '0, pres = '0, exp_res = '0;
  logic [OW-1:0] pop = '0;
  logic          pz = 1'b0, exp_z = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    grant_edge = -10;
    free_at    = 0;
    ptr        = 1'b0;
    gidx       = 1'b0;
    exp_res    = '0;
    exp_z      = 1'b0;
  endtask

  // One clock: decide the grant from the inputs before the edge, then compare after it.
  task automatic tick();
    logic ex, dn;
    if (rst_n && (edge_n + 1 >= free_at) && (req0 || req1)) begin
      gidx = (req0 && req1) ? ptr : req1;
      ptr  = ~gidx;
      pa   = gidx ? a1 : a0;
      pb   = gidx ? b1 : b0;
      pop  = gidx ? op1 : op0;
      pres = ref_alu(pop, pa, pb);
      pz   = (pres == {W{1'b0}});
      grant_edge = edge_n + 1;
      free_at    = edge_n + 4;
    end
    @(posedge clk);
    edge_n++;
    #1;
    ex = (edge_n == grant_edge);
    dn = (edge_n == grant_edge + 1);
    if (dn) begin
      exp_res = pres;
      exp_z   = pz;
      order_q.push_back(int'(gidx));
    end
    if (done0) cnt_d0++;
    if (done1) cnt_d1++;
    chk("done0", 32'(done0), 32'(dn && !gidx));
    chk("done1", 32'(done1), 32'(dn && gidx));
    chk("both_done", 32'(done0 && done1), 32'd0);
    chk("busy", 32'(busy), 32'(ex || dn));
    chk("result", 32'(result), 32'(exp_res));
    chk("z", 32'(z), 32'(exp_z));
    chk("alu_a", 32'(alu_a), 32'(ex ? pa : {W{1'b0}}));
    chk("alu_b", 32'(alu_b), 32'(ex ? pb : {W{1'b0}}));
    chk("alu_op", 32'(alu_op), 32'(ex ? pop : {OW{1'b0}}));
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done0", 32'(done0), 32'd0);
    chk("rst_done1", 32'(done1), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_z", 32'(z), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    req0 = 1'b0; req1 = 1'b0; op0 = '0; op1 = '0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    #1 rst_n = 1'b0;
    do_reset(2);

    // Single ADD from requester 0.
    req0 = 1'b1; op0 = ALU_OP_ADD; a0 = 16'h0003; b0 = 16'h0004;
    cnt_d1 = 0;
    tick();
    req0 = 1'b0;
    tick();
    chk("add_done0", 32'(done0), 32'd1);
    chk("add_result", 32'(result), 32'h0007);
    chk("add_z", 32'(z), 32'd0);
    tick(); tick();
    chk("add_no_done1", 32'(cnt_d1), 32'd0);

    // Both requesters from reset: 0 first, then 1.
    do_reset(1);
    req0 = 1'b1; op0 = ALU_OP_ADD; a0 = 16'd1; b0 = 16'd1;
    req1 = 1'b1; op1 = ALU_OP_SUB; a1 = 16'd5; b1 = 16'd5;
    tick();
    req0 = 1'b0;
    tick();
    chk("rr_first_done0", 32'(done0), 32'd1);
    chk("rr_first_result", 32'(result), 32'h0002);
    chk("rr_first_z", 32'(z), 32'd0);
    tick(); tick();
    req1 = 1'b0;
    tick();
    chk("rr_second_done1", 32'(done1), 32'd1);
    chk("rr_second_result", 32'(result), 32'h0000);
    chk("rr_second_z", 32'(z), 32'd1);
    tick();

    // Continuous contention for 12 cycles alternates grants.
    do_reset(1);
    order_q.delete();
    cnt_d0 = 0; cnt_d1 = 0;
    req0 = 1'b1; req1 = 1'b1;
    repeat (12) tick();
    req0 = 1'b0; req1 = 1'b0;
    chk("alt_pulses", 32'(cnt_d0 + cnt_d1), 32'd4);
    chk("alt_count", 32'(order_q.size()), 32'd4);
    for (int i = 0; i < order_q.size(); i++) chk("alt_order", 32'(order_q[i]), 32'(i % 2));
    tick(); tick(); tick();

    // Operands changed after the grant are ignored.
    req1 = 1'b1; op1 = ALU_OP_SUB; a1 = 16'h0000; b1 = 16'h0001;
    tick();
    req1 = 1'b0; a1 = 16'h0005; b1 = 16'h0005;
    tick();
    chk("latch_result", 32'(result), 32'h0000_FFFF);
    chk("latch_z", 32'(z), 32'd0);
    tick();

    // Reset during EXEC abandons the operation.
    req0 = 1'b1; op0 = ALU_OP_ADD; a0 = 16'd9; b0 = 16'd9;
    tick();
    req0 = 1'b0;
    do_reset(1);
    cnt_d0 = 0;
    tick(); tick(); tick();
    chk("abandon_no_done0", 32'(cnt_d0), 32'd0);
    req1 = 1'b1; op1 = ALU_OP_SUB; a1 = 16'd8; b1 = 16'd3;
    tick();
    req1 = 1'b0;
    tick();
    chk("after_rst_done1", 32'(done1), 32'd1);
    chk("after_rst_result", 32'(result), 32'h0005);
    tick();

    // Request dropped during EXEC still completes, then stays idle.
    req0 = 1'b1; op0 = ALU_OP_ADD; a0 = 16'h1234; b0 = 16'h1111;
    tick();
    req0 = 1'b0;
    tick();
    chk("drop_done0", 32'(done0), 32'd1);
    chk("drop_result", 32'(result), 32'h2345);
    repeat (4) tick();
    chk("drop_idle", 32'(busy), 32'd0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) req0 = ~req0;
      if ($urandom_range(0, 2) == 0) req1 = ~req1;
      op0 = OW'($urandom_range(0, 3));
      op1 = OW'($urandom_range(0, 3));
      a0 = ($urandom_range(0, 3) == 0) ? b0 : W'($urandom);
      b0 = W'($urandom);
      a1 = W'($urandom);
      b1 = ($urandom_range(0, 3) == 0) ? a1 : W'($urandom);
      if ($urandom_range(0, 99) == 0) do_reset(1);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
